// File: rtl/boot_pkg.sv
// Shared types and constants for the boot sequencer.
// BOOT_CHECKSUM_EN adds the CHK state used to verify the frame checksum byte.
package boot_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
`ifdef BOOT_CHECKSUM_EN
    ST_CHK,
`endif
    ST_RUN,
    ST_ERR
  } boot_state_e;

endpackage

// File: rtl/boot_sequencer_if.sv
// Byte receive / reload inputs and instruction-memory write port of the boot sequencer.
interface boot_sequencer_if;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        reload_i;
  logic        imem_we_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_wdata_o;

  modport master (
    output rx_valid_i, rx_data_i, reload_i,
    input  imem_we_o, imem_addr_o, imem_wdata_o
  );

  modport slave (
    input  rx_valid_i, rx_data_i, reload_i,
    output imem_we_o, imem_addr_o, imem_wdata_o
  );
endinterface

// File: rtl/boot_sequencer_byte_packer.sv
// Packs little-endian bytes into 32-bit words; o_done pulses for one cycle
// after the fourth byte, with o_word holding the word until the next one completes.
module byte_packer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic        o_last,
  output logic [31:0] o_word,
  output logic        o_done
);

  logic [1:0]  r_idx;
  logic [23:0] r_shift;
  logic [31:0] r_word;
  logic        r_done;

  assign o_last = (r_idx == 2'd3);
  assign o_word = r_word;
  assign o_done = r_done;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_idx   <= 2'd0;
      r_shift <= 24'd0;
      r_word  <= 32'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_clear) begin
        r_idx <= 2'd0;
      end else if (i_valid) begin
        // Shift right so the first byte ends up in bits [7:0]
        r_shift <= {i_byte, r_shift[23:8]};
        r_idx   <= r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          r_word <= {i_byte, r_shift};
          r_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/boot_sequencer.sv
// Boot loader FSM: parses SYNC/count header, streams payload words into instruction memory,
// then releases the CPU. Define BOOT_CHECKSUM_EN to require a trailing mod-256 payload checksum.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int         IMEM_WORDS = 256,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic            clk_i,
  input  logic            reset_i,
  boot_sequencer_if.slave bus,
  output logic            cpu_reset_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam logic [16:0] MAX_WORDS = 17'(IMEM_WORDS);

  boot_state_e r_state, w_next;
  logic [15:0] r_count, r_word_idx, w_hdr_count;
  logic [31:0] r_addr, w_pk_word;
  logic        w_rx, w_data_acc, w_word_cplt, w_pk_clear, w_pk_last, w_pk_done, w_bad_count;

  // A coinciding reload always wins over the byte
  assign w_rx        = bus.rx_valid_i & ~bus.reload_i;
  assign w_hdr_count = {bus.rx_data_i, r_count[7:0]};
  assign w_bad_count = (w_hdr_count == 16'd0) || ({1'b0, w_hdr_count} > MAX_WORDS);
  assign w_data_acc  = (r_state == ST_DATA) && w_rx && (r_word_idx != r_count);
  assign w_word_cplt = w_data_acc && w_pk_last;

  byte_packer u_packer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .i_clear (w_pk_clear),
    .i_valid (w_data_acc),
    .i_byte  (bus.rx_data_i),
    .o_last  (w_pk_last),
    .o_word  (w_pk_word),
    .o_done  (w_pk_done)
  );

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] r_sum;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)        r_sum <= 8'd0;
    else if (w_pk_clear) r_sum <= 8'd0;
    else if (w_data_acc) r_sum <= r_sum + bus.rx_data_i;
  end
`endif

  always_comb begin
    w_next     = r_state;
    w_pk_clear = 1'b0;
    if (bus.reload_i) begin
      w_next     = ST_IDLE;
      w_pk_clear = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERR: if (w_rx && bus.rx_data_i == SYNC_BYTE) w_next = ST_HDR0;
        ST_HDR0:         if (w_rx) w_next = ST_HDR1;
        ST_HDR1: begin
          if (w_rx) begin
            w_next     = w_bad_count ? ST_ERR : ST_DATA;
            w_pk_clear = 1'b1;
          end
        end
`ifdef BOOT_CHECKSUM_EN
        // Leave DATA on the last byte so a back-to-back checksum byte lands in CHK
        ST_DATA: if (w_word_cplt && r_word_idx == r_count - 16'd1) w_next = ST_CHK;
        ST_CHK:  if (w_rx) w_next = (bus.rx_data_i == r_sum) ? ST_RUN : ST_ERR;
`else
        // Wait for the final write pulse so RUN starts the cycle after it
        ST_DATA: if (w_pk_done && r_word_idx == r_count) w_next = ST_RUN;
`endif
        ST_RUN:  w_next = ST_RUN;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state    <= ST_IDLE;
      r_count    <= 16'd0;
      r_word_idx <= 16'd0;
      r_addr     <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_HDR0 && w_rx) r_count[7:0]  <= bus.rx_data_i;
      if (r_state == ST_HDR1 && w_rx) r_count[15:8] <= bus.rx_data_i;
      if (w_pk_clear) begin
        r_word_idx <= 16'd0;
      end else if (w_word_cplt) begin
        r_word_idx <= r_word_idx + 16'd1;
        r_addr     <= {14'd0, r_word_idx, 2'b00};
      end
    end
  end

  assign cpu_reset_o      = (r_state != ST_RUN);
  assign err_o            = (r_state == ST_ERR);
`ifdef BOOT_CHECKSUM_EN
  assign busy_o           = (r_state == ST_HDR0) || (r_state == ST_HDR1) ||
                            (r_state == ST_DATA) || (r_state == ST_CHK);
`else
  assign busy_o           = (r_state == ST_HDR0) || (r_state == ST_HDR1) ||
                            (r_state == ST_DATA);
`endif
  assign bus.imem_we_o    = w_pk_done;
  assign bus.imem_addr_o  = r_addr;
  assign bus.imem_wdata_o = w_pk_word;

endmodule

// File: doc/boot_sequencer.md
BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 256, giving the instruction memory depth in 32-bit words (maximum loadable count).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, giving the load-frame start marker.
REQ-003 clk_i  in  1  single clock; all logic SHALL be in this domain.
REQ-004 reset_i  in  1  asynchronous, active-low reset.
REQ-005 rx_valid_i  in  1  one-cycle strobe; rx_data_i is valid this cycle.
REQ-006 rx_data_i  in  8  received byte.
REQ-007 reload_i  in  1  one-cycle request to halt the processor and await a new frame.
REQ-008 cpu_reset_o  out  1  active-high hold-in-reset for the processor core.
REQ-009 imem_we_o  out  1  one-cycle instruction memory write strobe.
REQ-010 imem_addr_o  out  32  byte address of the write (word index times 4).
REQ-011 imem_wdata_o  out  32  assembled instruction word.
REQ-012 busy_o  out  1  high while the frame is in HDR0, HDR1, DATA or CHK.
REQ-013 err_o  out  1  high in ERR.

Function
REQ-014 States SHALL be IDLE, HDR0, HDR1, DATA, CHK, RUN and ERR; only RUN SHALL drive cpu_reset_o=0.
REQ-015 IDLE: rx byte == SYNC_BYTE -> HDR0; other bytes ignored.
REQ-016 HDR0: byte captured as count[7:0] -> HDR1.
REQ-017 HDR1: byte captured as count[15:8]; count==0 or count>IMEM_WORDS -> ERR, else -> DATA with word_idx=0 and byte_idx=0.
REQ-018 DATA: bytes SHALL be packed little-endian (byte 0 -> bits [7:0]); byte_idx wraps 3->0.
REQ-019 DATA: imem_we_o SHALL pulse exactly one cycle, the cycle after the 4th byte is accepted, with imem_addr_o={word_idx,2'b00}; word_idx SHALL then increment.
REQ-020 DATA: on the write of word count-1 -> CHK if BOOT_CHECKSUM_EN, else -> RUN; RUN SHALL be entered no earlier than the cycle after the final write.
REQ-021 RUN: rx bytes ignored; reload_i -> IDLE with cpu_reset_o=1 in the next cycle.
REQ-022 ERR: cpu held in reset; SYNC_BYTE -> HDR0 and err_o clears.
REQ-023 reload_i outside RUN SHALL abort any frame -> IDLE with no further write; if reload_i and rx_valid_i coincide, reload wins and the byte is discarded.
REQ-024 imem_addr_o and imem_wdata_o SHALL hold their last values when imem_we_o=0.
REQ-025 At most one byte SHALL be consumed per cycle; back-to-back rx_valid_i on consecutive cycles SHALL be accepted without loss.

Reset
REQ-026 reset_i low SHALL immediately force IDLE, cpu_reset_o=1, imem_we_o=0, busy_o=0, err_o=0 and imem_addr_o=imem_wdata_o=0, and SHALL clear all counters and the checksum.
REQ-027 Reset during DATA SHALL discard the partial word; no write SHALL occur after reset asserts.

Configuration
REQ-028 With BOOT_CHECKSUM_EN defined, the block SHALL keep an 8-bit mod-256 sum of all payload bytes (header excluded); in CHK the next byte is compared: match -> RUN, mismatch -> ERR.
REQ-029 Without BOOT_CHECKSUM_EN, the CHK state and the sum register SHALL be absent and DATA SHALL go directly to RUN.

Structure
REQ-030 Package boot_pkg SHALL hold the state enum type and the SYNC_BYTE default constant.
REQ-031 Byte-to-word packing (byte_idx, shift register, word-done flag) SHALL be sub-module byte_packer; boot_sequencer holds the FSM and counters.

Verification
REQ-032 Frame A5,02,00,13,00,00,00,93,00,10,00 -> writes 0x00000013 @0x0 and 0x00100093 @0x4, then cpu_reset_o=0.
REQ-033 Frame A5,00,00 -> err_o=1 with no write; frame A5,01,01 with IMEM_WORDS=256 (count 257) -> err_o=1; a subsequent valid frame recovers to RUN.
REQ-034 Reset pulse after byte 2 of word 1 -> no write @0x4, IDLE, cpu_reset_o=1; full frame afterwards loads correctly.
REQ-035 In RUN, assert reload_i with rx_valid_i=1 and rx_data_i=A5 in the same cycle -> IDLE, byte dropped, cpu_reset_o=1 next cycle.
REQ-036 BOOT_CHECKSUM_EN: one-word frame 13,00,00,00 with checksum 13 -> RUN; with checksum 14 -> ERR, cpu held in reset.
REQ-037 Bytes on every cycle for a 256-word frame -> 256 single-cycle writes with addresses 0x000..0x3FC and no dropped byte.
